// File: rtl/rggen_indirect_access_initiator.sv
// Indirect register access initiator: writes the index register, then reads or
// writes the data register. Optional bus timeout via RGGEN_INDIRECT_ACCESS_TIMEOUT_EN.
module rggen_indirect_access_initiator #(
   parameter int                       ADDRESS_WIDTH  = 8,
   parameter int                       BUS_WIDTH      = 32,
   parameter int                       INDEX_WIDTH    = 8,
   parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS  = 'h00,
   parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS   = 'h04,
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic                     i_req_write,
   input  logic [INDEX_WIDTH-1:0]   i_req_index,
   input  logic [BUS_WIDTH-1:0]     i_req_write_data,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [1:0]               o_rsp_status,
   output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
   output logic                     o_bus_valid,
   output logic                     o_bus_write,
   output logic [ADDRESS_WIDTH-1:0] o_bus_address,
   output logic [BUS_WIDTH-1:0]     o_bus_write_data,
   output logic [BUS_WIDTH-1:0]     o_bus_strobe,
   input  logic                     i_bus_ready,
   input  logic [1:0]               i_bus_status,
   input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

   typedef enum logic [1:0] {
      IDLE,
      INDEX,
      DATA,
      RESPOND
   } state_e;

   localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

   if (INDEX_WIDTH < 1 || INDEX_WIDTH > BUS_WIDTH) begin : g_bad_index_width
      $error("INDEX_WIDTH must be within 1..BUS_WIDTH");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..65535");
   end

   state_e                 state;
   logic                   write_q;
   logic [INDEX_WIDTH-1:0] index_q;
   logic [BUS_WIDTH-1:0]   data_q;
   logic                   timeout;

`ifdef RGGEN_INDIRECT_ACCESS_TIMEOUT_EN
   logic [15:0] wait_count;

   // Fires on the last permitted wait cycle so o_bus_valid drops right after it.
   assign timeout = o_bus_valid && !i_bus_ready &&
                    (wait_count == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wait_count <= '0;
      end else if (o_bus_valid && !i_bus_ready && !timeout) begin
         wait_count <= wait_count + 16'd1;
      end else begin
         wait_count <= '0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // NOTE: every state register uses <= so all flops sample the same pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state            <= IDLE;
         write_q          <= 1'b0;
         index_q          <= '0;
         data_q           <= '0;
         o_req_ready      <= 1'b1;
         o_rsp_valid      <= 1'b0;
         o_rsp_status     <= '0;
         o_rsp_read_data  <= '0;
         o_bus_valid      <= 1'b0;
         o_bus_write      <= 1'b0;
         o_bus_address    <= '0;
         o_bus_write_data <= '0;
         o_bus_strobe     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req_valid) begin
                  state            <= INDEX;
                  write_q          <= i_req_write;
                  index_q          <= i_req_index;
                  data_q           <= i_req_write_data;
                  o_req_ready      <= 1'b0;
                  o_bus_valid      <= 1'b1;
                  o_bus_write      <= 1'b1;
                  o_bus_address    <= INDEX_ADDRESS;
                  o_bus_write_data <= BUS_WIDTH'(i_req_index);
                  o_bus_strobe     <= '1;
               end
            end
            INDEX: begin
               if (i_bus_ready && !i_bus_status[1]) begin
                  state            <= DATA;
                  o_bus_write      <= write_q;
                  o_bus_address    <= DATA_ADDRESS;
                  o_bus_write_data <= data_q;
                  o_bus_strobe     <= write_q ? '1 : '0;
               end else if (i_bus_ready || timeout) begin
                  // Index write failed: the data phase is skipped entirely.
                  state            <= RESPOND;
                  o_rsp_valid      <= 1'b1;
                  o_rsp_status     <= i_bus_ready ? i_bus_status : STATUS_SLAVE_ERROR;
                  o_rsp_read_data  <= '0;
                  o_bus_valid      <= 1'b0;
                  o_bus_write      <= 1'b0;
                  o_bus_address    <= '0;
                  o_bus_write_data <= '0;
                  o_bus_strobe     <= '0;
               end
            end
            DATA: begin
               if (i_bus_ready || timeout) begin
                  state            <= RESPOND;
                  o_rsp_valid      <= 1'b1;
                  o_rsp_status     <= i_bus_ready ? i_bus_status : STATUS_SLAVE_ERROR;
                  o_rsp_read_data  <= (i_bus_ready && !write_q) ? i_bus_read_data : '0;
                  o_bus_valid      <= 1'b0;
                  o_bus_write      <= 1'b0;
                  o_bus_address    <= '0;
                  o_bus_write_data <= '0;
                  o_bus_strobe     <= '0;
               end
            end
            RESPOND: begin
               if (i_rsp_ready) begin
                  state           <= IDLE;
                  o_req_ready     <= 1'b1;
                  o_rsp_valid     <= 1'b0;
                  o_rsp_status    <= '0;
                  o_rsp_read_data <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   logic unused_index;
   assign unused_index = ^index_q;

endmodule

// File: tb/tb_rggen_indirect_access_initiator.sv
// Directed bench for rggen_indirect_access_initiator: table-driven cycle vectors
// plus hand-written reset and bus-wait sequences.
module tb_rggen_indirect_access_initiator;

   localparam logic [31:0] F = 32'hFFFF_FFFF;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [7:0]  i_req_index;
   logic [31:0] i_req_write_data;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [1:0]  o_rsp_status;
   logic [31:0] o_rsp_read_data;
   logic        o_bus_valid;
   logic        o_bus_write;
   logic [7:0]  o_bus_address;
   logic [31:0] o_bus_write_data;
   logic [31:0] o_bus_strobe;
   logic        i_bus_ready;
   logic [1:0]  i_bus_status;
   logic [31:0] i_bus_read_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   rggen_indirect_access_initiator #(
      .ADDRESS_WIDTH  (8),
      .BUS_WIDTH      (32),
      .INDEX_WIDTH    (8),
      .INDEX_ADDRESS  (8'h00),
      .DATA_ADDRESS   (8'h04),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_write      (i_req_write),
      .i_req_index      (i_req_index),
      .i_req_write_data (i_req_write_data),
      .o_rsp_valid      (o_rsp_valid),
      .i_rsp_ready      (i_rsp_ready),
      .o_rsp_status     (o_rsp_status),
      .o_rsp_read_data  (o_rsp_read_data),
      .o_bus_valid      (o_bus_valid),
      .o_bus_write      (o_bus_write),
      .o_bus_address    (o_bus_address),
      .o_bus_write_data (o_bus_write_data),
      .o_bus_strobe     (o_bus_strobe),
      .i_bus_ready      (i_bus_ready),
      .i_bus_status     (i_bus_status),
      .i_bus_read_data  (i_bus_read_data)
   );

   typedef struct {
      logic        req_valid;
      logic        req_write;
      logic [7:0]  req_index;
      logic [31:0] req_wdata;
      logic        bus_ready;
      logic [1:0]  bus_status;
      logic [31:0] bus_rdata;
      logic        rsp_ready;
      logic        e_req_ready;
      logic        e_bus_valid;
      logic        e_bus_write;
      logic [7:0]  e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_strobe;
      logic        e_rsp_valid;
      logic [1:0]  e_rsp_status;
      logic [31:0] e_rsp_data;
   } vec_t;

   localparam int NV = 21;
   vec_t vec [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic exp_req_ready);
      check({tag, " req_ready"}, 64'(o_req_ready), 64'(exp_req_ready));
      check({tag, " bus_valid"}, 64'(o_bus_valid), 64'd0);
      check({tag, " bus_write"}, 64'(o_bus_write), 64'd0);
      check({tag, " bus_addr"}, 64'(o_bus_address), 64'd0);
      check({tag, " bus_wdata"}, 64'(o_bus_write_data), 64'd0);
      check({tag, " bus_strobe"}, 64'(o_bus_strobe), 64'd0);
      check({tag, " rsp_valid"}, 64'(o_rsp_valid), 64'd0);
      check({tag, " rsp_status"}, 64'(o_rsp_status), 64'd0);
      check({tag, " rsp_data"}, 64'(o_rsp_read_data), 64'd0);
   endtask

   // Caller is positioned just after a rising edge.
   task automatic run_vectors(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         i_req_valid      = vec[i].req_valid;
         i_req_write      = vec[i].req_write;
         i_req_index      = vec[i].req_index;
         i_req_write_data = vec[i].req_wdata;
         i_bus_ready      = vec[i].bus_ready;
         i_bus_status     = vec[i].bus_status;
         i_bus_read_data  = vec[i].bus_rdata;
         i_rsp_ready      = vec[i].rsp_ready;
         @(negedge i_clk);
         check($sformatf("v%0d req_ready", i), 64'(o_req_ready), 64'(vec[i].e_req_ready));
         check($sformatf("v%0d bus_valid", i), 64'(o_bus_valid), 64'(vec[i].e_bus_valid));
         check($sformatf("v%0d bus_write", i), 64'(o_bus_write), 64'(vec[i].e_bus_write));
         check($sformatf("v%0d bus_addr", i), 64'(o_bus_address), 64'(vec[i].e_addr));
         check($sformatf("v%0d bus_wdata", i), 64'(o_bus_write_data), 64'(vec[i].e_wdata));
         check($sformatf("v%0d bus_strobe", i), 64'(o_bus_strobe), 64'(vec[i].e_strobe));
         check($sformatf("v%0d rsp_valid", i), 64'(o_rsp_valid), 64'(vec[i].e_rsp_valid));
         check($sformatf("v%0d rsp_status", i), 64'(o_rsp_status), 64'(vec[i].e_rsp_status));
         check($sformatf("v%0d rsp_data", i), 64'(o_rsp_read_data), 64'(vec[i].e_rsp_data));
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      i_req_valid      = 1'b0;
      i_req_write      = 1'b0;
      i_req_index      = '0;
      i_req_write_data = '0;
      i_bus_ready      = 1'b0;
      i_bus_status     = 2'b00;
      i_bus_read_data  = '0;
      i_rsp_ready      = 1'b0;
   endtask

   int valid_cycles;

   initial begin
      // Write idx 05 / DEADBEEF, bus ready tied high; read data on a write must be dropped.
      vec[0]  = '{1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b1, 2'b00, 32'h0, 1'b1,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vec[1]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b0, 1'b1, 1'b1, 8'h00, 32'h5, F,     1'b0, 2'b00, 32'h0};
      vec[2]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'hBAD00000, 1'b1,  1'b0, 1'b1, 1'b1, 8'h04, 32'hDEADBEEF, F, 1'b0, 2'b00, 32'h0};
      vec[3]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0};
      vec[4]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      // Read idx 03, two DATA wait cycles, EXOKAY; requests driven mid-access are ignored;
      // response held for five cycles before the handshake.
      vec[5]  = '{1'b1, 1'b0, 8'h03, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vec[6]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b0, 1'b1, 1'b1, 8'h00, 32'h3, F,     1'b0, 2'b00, 32'h0};
      vec[7]  = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b1,         1'b0, 1'b1, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vec[8]  = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b1,         1'b0, 1'b1, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vec[9]  = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b1, 2'b01, 32'h12345678, 1'b1,  1'b0, 1'b1, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vec[10] = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h12345678};
      vec[11] = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h12345678};
      vec[12] = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h12345678};
      vec[13] = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h12345678};
      vec[14] = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h12345678};
      vec[15] = '{1'b1, 1'b1, 8'h07, 32'h11111111, 1'b0, 2'b00, 32'h0, 1'b1,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h12345678};
      vec[16] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 2'b00, 32'h0, 1'b0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      // Index phase returns DECODE_ERROR: no data phase, read data 0.
      vec[17] = '{1'b1, 1'b1, 8'h09, 32'h55,       1'b1, 2'b11, 32'h0, 1'b1,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};
      vec[18] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b11, 32'hCAFE0000, 1'b1,  1'b0, 1'b1, 1'b1, 8'h00, 32'h9, F,     1'b0, 2'b00, 32'h0};
      vec[19] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 2'b11, 32'h0};
      vec[20] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 2'b00, 32'h0, 1'b1,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0};

      idle_inputs();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset bus_valid", 64'(o_bus_valid), 64'd0);
      check("reset rsp_valid", 64'(o_rsp_valid), 64'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      check_idle_outputs("post-reset", 1'b1);
      @(posedge i_clk);
      #1;

      run_vectors(0, NV - 1);

      // Reset during a stalled DATA phase.
      i_req_valid = 1'b1;
      i_req_write = 1'b0;
      i_req_index = 8'h02;
      i_bus_ready = 1'b1;
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      @(posedge i_clk);
      #1;
      i_bus_ready = 1'b0;
      @(posedge i_clk);
      #1;
      check("stall data bus_valid", 64'(o_bus_valid), 64'd1);
      check("stall data bus_addr", 64'(o_bus_address), 64'h04);
      #2;
      i_rst = 1'b1;
      #1;
      check("mid-reset bus_valid", 64'(o_bus_valid), 64'd0);
      check("mid-reset bus_addr", 64'(o_bus_address), 64'd0);
      check("mid-reset bus_write", 64'(o_bus_write), 64'd0);
      check("mid-reset bus_strobe", 64'(o_bus_strobe), 64'd0);
      check("mid-reset rsp_valid", 64'(o_rsp_valid), 64'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      idle_inputs();
      @(negedge i_clk);
      check_idle_outputs("after mid-reset", 1'b1);
      @(posedge i_clk);
      #1;
      run_vectors(0, 4);

      // Bus never ready during the index phase.
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_index = 8'h01;
      i_req_write_data = 32'h0000_00AA;
      i_bus_ready = 1'b0;
      i_rsp_ready = 1'b0;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      valid_cycles = 0;
`ifdef RGGEN_INDIRECT_ACCESS_TIMEOUT_EN
      for (int c = 0; c < 20; c++) begin
         @(negedge i_clk);
         if (!o_bus_valid) break;
         valid_cycles++;
      end
      check("timeout valid cycles", 64'(valid_cycles), 64'd4);
      check("timeout rsp_valid", 64'(o_rsp_valid), 64'd1);
      check("timeout rsp_status", 64'(o_rsp_status), 64'h2);
      check("timeout rsp_data", 64'(o_rsp_read_data), 64'd0);
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      check_idle_outputs("after timeout", 1'b1);
`else
      for (int c = 0; c < 12; c++) begin
         @(negedge i_clk);
         if (o_bus_valid) valid_cycles++;
      end
      check("no-timeout valid cycles", 64'(valid_cycles), 64'd12);
      check("no-timeout bus_addr", 64'(o_bus_address), 64'h00);
      check("no-timeout rsp_valid", 64'(o_rsp_valid), 64'd0);
      @(posedge i_clk);
      #1;
      i_bus_ready = 1'b1;
      i_bus_status = 2'b00;
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      #1;
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      check("late ready rsp_valid", 64'(o_rsp_valid), 64'd1);
      check("late ready rsp_status", 64'(o_rsp_status), 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
